// File: rtl/mul_rs_pkg.sv
// mul_rs_pkg: shared tag constants and the reservation-station entry layout.
package mul_rs_pkg;
    localparam int TAG_WIDTH = 4;
    localparam logic [TAG_WIDTH-1:0] NO_TAG = '1;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] qj;
        logic [TAG_WIDTH-1:0] qk;
        logic [31:0]          vj;
        logic [31:0]          vk;
    } rs_entry_t;
endpackage

// File: rtl/rs_pick_ready.sv
// rs_pick_ready: grants the ready request with the smallest age rank; ties go to the lowest index.
module rs_pick_ready #(
    parameter int N  = 4,
    parameter int AW = $clog2(N)
) (
    input  logic [N-1:0]         ready_i,
    input  logic [N-1:0][AW-1:0] age_i,
    output logic [N-1:0]         grant_o,
    output logic [AW-1:0]        idx_o,
    output logic                 valid_o
);
    logic [AW-1:0] best;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        best    = '0;
        for (int i = 0; i < N; i++) begin
            if (ready_i[i] && (!valid_o || age_i[i] < best)) begin
                valid_o = 1'b1;
                idx_o   = AW'(i);
                best    = age_i[i];
            end
        end
        grant_o = valid_o ? N'(1) << idx_o : '0;
    end
endmodule

// File: rtl/mul_rs_scheduler.sv
// mul_rs_scheduler: multiplier reservation station with CDB wakeup and single-issue scheduling.
// Define AGE_PRIORITY_EN to issue the oldest ready entry instead of the lowest ready index.
module mul_rs_scheduler
    import mul_rs_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int TAG_BASE = 4,
    parameter int TAG_W    = TAG_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [TAG_W-1:0]           alloc_qj,
    input  logic [TAG_W-1:0]           alloc_qk,
    input  logic [31:0]                alloc_vj,
    input  logic [31:0]                alloc_vk,
    output logic [TAG_W-1:0]           alloc_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [31:0]                cdb_data,
    output logic                       mul_calculate,
    output logic [31:0]                mul_a,
    output logic [31:0]                mul_b,
    output logic [TAG_W-1:0]           mul_row,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    rs_entry_t               ent_q [DEPTH];
    rs_entry_t               ent_d [DEPTH];
    rs_entry_t               new_ent;
    logic [DEPTH-1:0]        ready, grant;
    logic [DEPTH-1:0][IW-1:0] age;
    logic [IW-1:0]           pick_idx, free_idx;
    logic                    pick_valid, alloc_fire, wake;
    logic                    calc_q;
    logic [31:0]             a_q, b_q;
    logic [TAG_W-1:0]        row_q;

    always_comb begin
        occupancy = '0;
        free_idx  = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            occupancy = occupancy + OW'(ent_q[i].valid);
            free_idx  = ent_q[i].valid ? free_idx : IW'(i);
            ready[i]  = ent_q[i].valid && ent_q[i].qj == NO_TAG && ent_q[i].qk == NO_TAG;
        end
    end

    assign alloc_ready = occupancy < OW'(DEPTH) && !reset;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
    assign wake        = cdb_valid && cdb_tag != NO_TAG;

    // A result broadcast in the allocation cycle is captured directly instead of being missed.
    assign new_ent = '{
        valid: 1'b1,
        qj:    (wake && alloc_qj == cdb_tag) ? NO_TAG : alloc_qj,
        qk:    (wake && alloc_qk == cdb_tag) ? NO_TAG : alloc_qk,
        vj:    (wake && alloc_qj == cdb_tag) ? cdb_data : alloc_vj,
        vk:    (wake && alloc_qk == cdb_tag) ? cdb_data : alloc_vk
    };

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (wake && ent_q[i].valid && ent_q[i].qj == cdb_tag) begin
                ent_d[i].qj = NO_TAG;
                ent_d[i].vj = cdb_data;
            end
            if (wake && ent_q[i].valid && ent_q[i].qk == cdb_tag) begin
                ent_d[i].qk = NO_TAG;
                ent_d[i].vk = cdb_data;
            end
            if (grant[i]) ent_d[i].valid = 1'b0;
            if (alloc_fire && free_idx == IW'(i)) ent_d[i] = new_ent;
        end
    end

`ifdef AGE_PRIORITY_EN
    // Rank 0 is the oldest valid entry; ranks stay dense as entries leave.
    logic [DEPTH-1:0][IW-1:0] age_q, age_d;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            age_d[i] = age_q[i] - IW'(pick_valid && ent_q[i].valid && age_q[i] > age_q[pick_idx]);
        if (alloc_fire) age_d[free_idx] = IW'(occupancy - OW'(pick_valid));
    end

    always_ff @(posedge clk) begin
        if (reset) age_q <= '0;
        else       age_q <= age_d;
    end

    assign age = age_q;
`else
    always_comb begin
        for (int i = 0; i < DEPTH; i++) age[i] = IW'(i);
    end
`endif

    rs_pick_ready #(.N(DEPTH), .AW(IW)) u_pick (
        .ready_i (ready),
        .age_i   (age),
        .grant_o (grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q  <= '{default: '0};
            calc_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            row_q  <= NO_TAG;
        end else begin
            ent_q  <= ent_d;
            calc_q <= pick_valid;
            if (pick_valid) begin
                a_q   <= ent_q[pick_idx].vj;
                b_q   <= ent_q[pick_idx].vk;
                row_q <= TAG_W'(TAG_BASE) + TAG_W'(pick_idx);
            end
        end
    end

    assign mul_calculate = calc_q;
    assign mul_a         = a_q;
    assign mul_b         = b_q;
    assign mul_row       = row_q;
endmodule

// File: tb/tb_mul_rs_scheduler.sv
// tb_mul_rs_scheduler: directed plus randomized stimulus against a queue-based reference model.
module tb_mul_rs_scheduler;
    import mul_rs_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_BASE = 4;
`ifdef AGE_PRIORITY_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1, alloc_valid = 1'b0, cdb_valid = 1'b0;
    logic        alloc_ready, mul_calculate;
    logic [3:0]  alloc_qj = NO_TAG, alloc_qk = NO_TAG, cdb_tag = NO_TAG, alloc_tag, mul_row;
    logic [31:0] alloc_vj = '0, alloc_vk = '0, cdb_data = '0, mul_a, mul_b;
    logic [2:0]  occupancy;

    always #5 clk = ~clk;

    mul_rs_scheduler #(.DEPTH(DEPTH), .TAG_BASE(TAG_BASE), .TAG_W(4)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_qj(alloc_qj), .alloc_qk(alloc_qk), .alloc_vj(alloc_vj), .alloc_vk(alloc_vk),
        .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .mul_calculate(mul_calculate), .mul_a(mul_a), .mul_b(mul_b), .mul_row(mul_row),
        .occupancy(occupancy)
    );

    typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] row; } iss_t;
    iss_t exp_q[$];
    int checks = 0, failures = 0;

    // Reference model: slots with pending tags; readiness seen by the scheduler is last cycle's state.
    bit          m_v [DEPTH];
    logic [3:0]  m_qj [DEPTH], m_qk [DEPTH];
    logic [31:0] m_vj [DEPTH], m_vk [DEPTH];
    int          m_seq [DEPTH];
    int          seq_ctr = 0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [3:0]  m_row = NO_TAG;

    function automatic int count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_v[i]);
        return n;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < DEPTH; i++) if (!m_v[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] rtag();
        case ($urandom_range(0, 5))
            0: return 4'd0;
            1: return 4'd1;
            2: return 4'd2;
            3: return 4'd3;
            default: return NO_TAG;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int pick, fr;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
            m_a = '0;
            m_b = '0;
            m_row = NO_TAG;
        end else begin
            pick = -1;
            for (int i = 0; i < DEPTH; i++)
                if (m_v[i] && m_qj[i] == NO_TAG && m_qk[i] == NO_TAG)
                    if (pick < 0 || (AGE && m_seq[i] < m_seq[pick])) pick = i;
            fr = (count() < DEPTH) ? lowest_free() : -1;
            if (cdb_valid && cdb_tag != NO_TAG)
                for (int i = 0; i < DEPTH; i++) if (m_v[i]) begin
                    if (m_qj[i] == cdb_tag) begin m_qj[i] = NO_TAG; m_vj[i] = cdb_data; end
                    if (m_qk[i] == cdb_tag) begin m_qk[i] = NO_TAG; m_vk[i] = cdb_data; end
                end
            if (pick >= 0) begin
                m_a = m_vj[pick];
                m_b = m_vk[pick];
                m_row = 4'(TAG_BASE + pick);
                exp_q.push_back('{a: m_a, b: m_b, row: m_row});
                m_v[pick] = 1'b0;
            end
            if (alloc_valid && fr >= 0) begin
                m_v[fr] = 1'b1;
                m_qj[fr] = alloc_qj;
                m_qk[fr] = alloc_qk;
                m_vj[fr] = alloc_vj;
                m_vk[fr] = alloc_vk;
                if (cdb_valid && cdb_tag != NO_TAG && alloc_qj == cdb_tag) begin m_qj[fr] = NO_TAG; m_vj[fr] = cdb_data; end
                if (cdb_valid && cdb_tag != NO_TAG && alloc_qk == cdb_tag) begin m_qk[fr] = NO_TAG; m_vk[fr] = cdb_data; end
                m_seq[fr] = seq_ctr++;
            end
        end
    end

    always @(negedge clk) begin : monitor
        iss_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("issue_calc", 32'(mul_calculate), 32'd1);
            chk("issue_a", mul_a, e.a);
            chk("issue_b", mul_b, e.b);
            chk("issue_row", 32'(mul_row), 32'(e.row));
        end else begin
            chk("idle_calc", 32'(mul_calculate), 32'd0);
            chk("hold_a", mul_a, m_a);
            chk("hold_b", mul_b, m_b);
            chk("hold_row", 32'(mul_row), 32'(m_row));
        end
        chk("occupancy", 32'(occupancy), 32'(count()));
    end

    task automatic drive(input bit rst, input bit av, input logic [3:0] qj, input logic [3:0] qk,
                         input logic [31:0] vj, input logic [31:0] vk,
                         input bit cv, input logic [3:0] ct, input logic [31:0] cd, output bit acc);
        bit exp_rdy;
        @(posedge clk);
        #2;
        reset = rst; alloc_valid = av; alloc_qj = qj; alloc_qk = qk; alloc_vj = vj; alloc_vk = vk;
        cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
        #1;
        exp_rdy = !rst && count() < DEPTH;
        acc = av && exp_rdy;
        chk("alloc_ready", 32'(alloc_ready), 32'(exp_rdy));
        if (exp_rdy) chk("alloc_tag", 32'(alloc_tag), 32'(TAG_BASE + lowest_free()));
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, NO_TAG, NO_TAG, '0, '0, 1'b0, NO_TAG, '0, acc);
    endtask

    task automatic bcast(input logic [3:0] t, input logic [31:0] d);
        bit acc;
        drive(1'b0, 1'b0, NO_TAG, NO_TAG, '0, '0, 1'b1, t, d, acc);
    endtask

    task automatic send_op(input logic [3:0] qj, input logic [3:0] qk, input logic [31:0] vj, input logic [31:0] vk);
        bit acc = 1'b0;
        for (int n = 0; n < 40 && !acc; n++) drive(1'b0, 1'b1, qj, qk, vj, vk, 1'b0, NO_TAG, '0, acc);
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL alloc_timeout actual=not_accepted expected=accepted at %0t", $time);
        end
    endtask

    initial begin : stim
        bit acc, have, rst;
        logic [3:0] pqj, pqk;
        logic [31:0] pvj, pvk;
        drive(1'b1, 1'b0, NO_TAG, NO_TAG, '0, '0, 1'b0, NO_TAG, '0, acc);
        drive(1'b1, 1'b0, NO_TAG, NO_TAG, '0, '0, 1'b0, NO_TAG, '0, acc);
        send_op(NO_TAG, NO_TAG, 32'd3, 32'd7);
        idle(3);
        send_op(4'd2, NO_TAG, 32'd0, 32'd5);
        idle(2);
        bcast(4'd2, 32'd6);
        idle(3);
        drive(1'b0, 1'b1, NO_TAG, 4'd9, 32'd8, 32'd0, 1'b1, 4'd9, 32'd11, acc);
        idle(3);
        for (int i = 0; i < DEPTH; i++) send_op(4'd1, NO_TAG, 32'd0, 32'(10 + i));
        drive(1'b0, 1'b1, 4'd2, NO_TAG, 32'd50, 32'd60, 1'b0, NO_TAG, '0, acc);
        drive(1'b0, 1'b1, 4'd2, NO_TAG, 32'd50, 32'd60, 1'b1, 4'd1, 32'd100, acc);
        send_op(4'd2, NO_TAG, 32'd50, 32'd60);
        idle(6);
        bcast(4'd2, 32'd5);
        idle(4);
        send_op(NO_TAG, NO_TAG, 32'd1, 32'd2);
        send_op(NO_TAG, NO_TAG, 32'd3, 32'd4);
        send_op(4'd3, NO_TAG, 32'd0, 32'd6);
        send_op(4'd3, NO_TAG, 32'd0, 32'd8);
        bcast(4'd3, 32'd9);
        idle(4);
        for (int i = 0; i < 3; i++) send_op(4'd1, NO_TAG, 32'(i), 32'(i));
        drive(1'b1, 1'b0, NO_TAG, NO_TAG, '0, '0, 1'b1, 4'd1, 32'd77, acc);
        idle(4);
        have = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!have && $urandom_range(0, 2) != 0) begin
                have = 1'b1;
                pqj = rtag();
                pqk = rtag();
                pvj = $urandom;
                pvk = $urandom;
            end
            drive(rst, have, pqj, pqk, pvj, pvk, 1'($urandom_range(0, 1)), rtag(), $urandom, acc);
            if (acc) have = 1'b0;
        end
        for (int t = 0; t < 4; t++) bcast(4'(t), $urandom);
        idle(10);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
